// File: rtl/ebpc_pkg.sv
// rtl/ebpc_pkg.sv - shared widths and state types for the EBPC decompression path
package ebpc_pkg;

    localparam int DATA_W           = 8;
    localparam int LOG_MAX_ZRLE_LEN = 4;
    localparam int MAX_ZRLE_LEN     = 1 << LOG_MAX_ZRLE_LEN;
    localparam int ZRLE_CNT_W       = 12;
    localparam int ZRLE_FILL_W      = $clog2(2 * DATA_W + 1);
    localparam int ZRLE_RUN_W       = LOG_MAX_ZRLE_LEN + 1;

    typedef enum logic [1:0] {
        ZRLD_IDLE,
        ZRLD_DECODE,
        ZRLD_ZEROS,
        ZRLD_DRAIN
    } zrld_state_t;

endpackage

// File: rtl/zrld.sv
// rtl/zrld.sv - zero-run-length decoder, packed ZRLE words to one zero/non-zero flag per cycle
module zrld
    import ebpc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  last_i,
    input  logic [ZRLE_CNT_W-1:0] num_bits_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic                  is_one_o,
    output logic                  last_o,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int BUF_W = 2 * DATA_W;
    localparam int SYM_W = 1 + LOG_MAX_ZRLE_LEN;

    zrld_state_t              state_q, state_d;
    logic [BUF_W-1:0]         buf_q, buf_d;
    logic [ZRLE_FILL_W-1:0]   fill_q, fill_d;
    logic [ZRLE_CNT_W-1:0]    rem_q, rem_d;
    logic [ZRLE_RUN_W-1:0]    run_q, run_d;
    logic                     seen_last_q, seen_last_d;

    logic                        msb;
    logic [LOG_MAX_ZRLE_LEN-1:0] field;
    logic                        have_sym;
    logic [BUF_W-1:0]            word_al;
    logic [ZRLE_FILL_W-1:0]      consume;
    logic [ZRLE_FILL_W-1:0]      left;
    logic                        in_hs;
    logic                        out_hs;
    logic                        trunc;
    logic                        clear;

    assign msb      = buf_q[BUF_W-1];
    assign field    = buf_q[BUF_W-2 -: LOG_MAX_ZRLE_LEN];
    assign have_sym = fill_q >= ZRLE_FILL_W'(SYM_W);
    assign word_al  = {data_i, {DATA_W{1'b0}}};

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        run_d       = run_q;
        seen_last_d = seen_last_q;
        rdy_o       = 1'b0;
        idle_o      = 1'b0;
        vld_o       = 1'b0;
        is_one_o    = 1'b0;
        last_o      = 1'b0;
        err_o       = 1'b0;
        consume     = '0;
        left        = '0;
        in_hs       = 1'b0;
        out_hs      = 1'b0;
        trunc       = 1'b0;
        clear       = 1'b0;

        case (state_q)
            ZRLD_IDLE: begin
                rdy_o  = 1'b1;
                idle_o = !vld_i;
                if (vld_i) begin
                    buf_d       = word_al;
                    fill_d      = ZRLE_FILL_W'(DATA_W);
                    rem_d       = num_bits_i;
                    run_d       = '0;
                    seen_last_d = last_i;
                    if (num_bits_i == '0) begin
                        state_d = last_i ? ZRLD_IDLE : ZRLD_DRAIN;
                    end else begin
                        state_d = ZRLD_DECODE;
                    end
                end
            end
            ZRLD_DECODE: begin
                rdy_o = (fill_q <= ZRLE_FILL_W'(DATA_W)) && !seen_last_q;
                if (fill_q != '0 && msb) begin
                    vld_o    = 1'b1;
                    is_one_o = 1'b1;
                    if (rdy_i) consume = ZRLE_FILL_W'(1);
                end else if (!msb && have_sym) begin
                    // The symbol itself carries the first zero; run holds the rest.
                    vld_o = 1'b1;
                    trunc = field != '0;
                    if (rdy_i) begin
                        consume = ZRLE_FILL_W'(SYM_W);
                        run_d   = ZRLE_RUN_W'(field);
                        if (field != '0) state_d = ZRLD_ZEROS;
                    end
                end else if (seen_last_q) begin
                    err_o   = 1'b1;
                    state_d = ZRLD_IDLE;
                    clear   = 1'b1;
                end
            end
            ZRLD_ZEROS: begin
                rdy_o = (fill_q <= ZRLE_FILL_W'(DATA_W)) && !seen_last_q;
                vld_o = 1'b1;
                trunc = run_q > ZRLE_RUN_W'(1);
                if (rdy_i) begin
                    run_d = run_q - ZRLE_RUN_W'(1);
                    if (run_q == ZRLE_RUN_W'(1)) state_d = ZRLD_DECODE;
                end
            end
            ZRLD_DRAIN: begin
                rdy_o = 1'b1;
                if (vld_i && last_i) begin
                    state_d = ZRLD_IDLE;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = ZRLD_IDLE;
                clear   = 1'b1;
            end
        endcase

        // Shift out consumed bits first, then land the new word just below what remains.
        if (state_q == ZRLD_DECODE || state_q == ZRLD_ZEROS) begin
            left   = fill_q - consume;
            buf_d  = buf_q << consume;
            fill_d = left;
            in_hs  = vld_i && rdy_o;
            if (in_hs) begin
                buf_d       = buf_d | (word_al >> left);
                fill_d      = left + ZRLE_FILL_W'(DATA_W);
                seen_last_d = last_i;
            end
        end

        out_hs = vld_o && rdy_i;
        last_o = vld_o && (rem_q == ZRLE_CNT_W'(1));
        if (out_hs) rem_d = rem_q - ZRLE_CNT_W'(1);
        if (out_hs && last_o) begin
            err_o   = trunc;
            state_d = (seen_last_q || (in_hs && last_i)) ? ZRLD_IDLE : ZRLD_DRAIN;
            clear   = 1'b1;
        end

        if (clear) begin
            buf_d  = '0;
            fill_d = '0;
            run_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ZRLD_IDLE;
            buf_q       <= '0;
            fill_q      <= '0;
            rem_q       <= '0;
            run_q       <= '0;
            seen_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            run_q       <= run_d;
            seen_last_q <= seen_last_d;
        end
    end

endmodule

// File: doc/zrld.md
# zrld

Zero-run-length decoder: the receive-side counterpart of the ZRLE encoder in the EBPC decompression path. It consumes a packed ZRLE bitstream as DATA_W-bit words and expands it back into a stream of single-bit zero/non-zero flags, one per cycle, for the bit-plane/value reconstruction stage.

Symbol format, MSB first:
- '1': one non-zero flag.
- '0' followed by a LOG_MAX_ZRLE_LEN-bit field n-1: a run of n zero flags, 1 ≤ n ≤ MAX_ZRLE_LEN.

Symbols may straddle word boundaries. The final word is zero-padded.

## Interface
Parameters: none. Widths come from ebpc_pkg: DATA_W, LOG_MAX_ZRLE_LEN, MAX_ZRLE_LEN, ZRLE_CNT_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- data_i  in  DATA_W  packed stream word, MSB = first bit
- last_i  in  1  marks the final word of a stream
- num_bits_i  in  ZRLE_CNT_W  number of flags to emit; sampled with the first word of a stream
- vld_i / rdy_o  in/out  1  input handshake
- is_one_o  out  1  decoded flag
- last_o  out  1  marks the final flag of a stream
- vld_o / rdy_i  out/in  1  output handshake
- idle_o  out  1  high in idle with no pending input
- err_o  out  1  one-cycle pulse on a malformed stream

## Operation
Internal state:
- buf: 2*DATA_W-bit shift register, MSB-aligned.
- fill: count of valid bits in buf, 0..2*DATA_W.
- rem: flags still to emit, ZRLE_CNT_W bits.
- run: zeros left in the current run, LOG_MAX_ZRLE_LEN+1 bits.
- seen_last: the last_i word has been accepted.

States:
- idle: rdy_o=1, idle_o=1 (idle_o drops while vld_i=1).
  - On vld_i: buf[2DW-1:DW]=data_i, fill=DW, rem=num_bits_i, seen_last=last_i.
  - Next state: decode. If num_bits_i==0, go to idle when last_i=1, else to drain.
- decode: examine buf MSB.
  - MSB '1': vld_o=1, is_one_o=1. On rdy_i: consume 1 bit.
  - MSB '0' with fill ≥ 1+LOG_MAX_ZRLE_LEN: vld_o=1, is_one_o=0 (first zero of the run). On rdy_i: consume 1+LOG_MAX_ZRLE_LEN bits and set run=field. If field≠0, go to zeros.
  - Insufficient bits (fill==0, or '0' with incomplete field): vld_o=0. If seen_last: pulse err_o and go to idle.
- zeros: vld_o=1, is_one_o=0. On rdy_i: run--. When run==1, go to decode.
- drain: rdy_o=1. Discard words until a last_i handshake, then go to idle.

Rules that apply in every state:
- Every output handshake decrements rem.
- last_o=vld_o&&(rem==1). A handshake with last_o goes to idle if seen_last, otherwise to drain. On that transition, clear buf, fill and run.
- A run longer than rem is truncated at rem. last_o is asserted as normal and err_o pulses with the final flag.
- Input accept in decode/zeros: rdy_o = (fill ≤ DATA_W) && !seen_last, from registered fill.
- On a same-cycle consume and accept, shift buf first, then OR data_i in at position fill-consumed.
- Widths: the fill arithmetic must not wrap. rem==0 is reachable only in idle/drain.

## Timing
- Reset values: vld_o, is_one_o, last_o, err_o = 0; rdy_o=1; idle_o=1. Reset mid-stream drops all state with no output.
- Latency: the first flag is valid on the cycle after the first word is accepted.
- Throughput: 1 flag/cycle, sustained while the input keeps fill ≥ 1+LOG_MAX_ZRLE_LEN.
- While vld_o=1 and rdy_i=0, is_one_o and last_o are held stable.
- rdy_o never depends combinationally on rdy_i.

## Structure
Add to ebpc_pkg:
- ZRLE_CNT_W.
- The state enum type zrld_state_t.

A single module with no sub-modules. The shifter plus fill logic is small enough to inline.

## Test plan
DATA_W=8, LOG_MAX_ZRLE_LEN=4:
1. num_bits=8, word 8'hFF with last → eight 1s, last_o on the 8th, then idle_o.
2. num_bits=4, word 8'h14 (0 0010 1) with last → 0,0,0,1, last_o on the 4th.
3. num_bits=17, word 8'h7C (0 1111 1) with last → sixteen 0s, then 1 with last_o.
4. num_bits=12, words 8'hFE then 8'h40 (straddling symbol) with random rdy_i stalls → seven 1s, five 0s. Outputs stay stable during every stall.
5. num_bits=10, word 8'hFF with last → eight 1s, then an err_o pulse, no last_o, return to idle.
6. num_bits=3, words 8'hFF (last=0) then 8'hAA (last=1) → 1,1,1 with last_o on the third flag. The second word is accepted and discarded, then idle_o.
